// File: rtl/shift_load_seq_pkg.sv
// Shared definitions for the shift-register load sequencer.
// Contents: FSM state encoding, default parameter values and the width of
// the optional load_count statistics output (SHIFT_LOAD_SEQ_STATS_EN).
package shift_load_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } seq_state_t;

  localparam int unsigned DEF_DATA_WIDTH   = 8;
  localparam int unsigned DEF_FIFO_DEPTH   = 4;
  localparam int unsigned DEF_HOLD_CYCLES  = 3;
  localparam int unsigned LOAD_COUNT_WIDTH = 8;

endpackage

// File: rtl/shift_load_fifo.sv
// Synchronous FIFO buffering words for the load sequencer.
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   push        write push_data (ignored when full)
//   push_data   word to write
//   pop         discard head word (ignored when empty)
//   full, empty occupancy flags derived from count
//   head        oldest buffered word (valid while !empty)
//   count       number of buffered words
module shift_load_fifo
  import shift_load_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: head is only consumed while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/shift_load_sequencer.sv
// Feeds a parallel-load shift register: buffers words from a valid/ready
// producer and issues one registered load pulse per word, followed by
// HOLD_CYCLES idle cycles so the register can shift the word out.
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   in_valid    producer offers in_data
//   in_data     word to load
//   in_ready    FIFO not full (transfer on in_valid & in_ready)
//   load        one-cycle load strobe
//   load_value  word presented with load; holds between pulses
//   busy        FIFO non-empty or FSM active
//   load_count  (only with SHIFT_LOAD_SEQ_STATS_EN) wrapping load counter
module shift_load_sequencer
  import shift_load_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  load,
  output logic [DATA_WIDTH-1:0] load_value,
  output logic                  busy
`ifdef SHIFT_LOAD_SEQ_STATS_EN
  ,
  output logic [LOAD_COUNT_WIDTH-1:0] load_count
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);

  seq_state_t            state;
  seq_state_t            state_next;
  logic [HW-1:0]         hold_cnt;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] head;
  logic [CW-1:0]         count;

  assign in_ready = ~full;
  assign push     = in_valid & in_ready;
  assign busy     = (count != '0) | (state != S_IDLE);

  shift_load_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head),
    .count     (count)
  );

  // State register, registered load strobe/value and hold counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      load       <= 1'b0;
      load_value <= '0;
      hold_cnt   <= '0;
    end else begin
      state <= state_next;
      load  <= pop;
      if (pop) load_value <= head;
      if (state == S_LOAD) begin
        hold_cnt <= HOLD_RELOAD;
      end else if ((state == S_HOLD) && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - HW'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!empty) state_next = S_LOAD;
      S_LOAD:  state_next = S_HOLD;
      S_HOLD:  if (hold_cnt == '0) state_next = empty ? S_IDLE : S_LOAD;
      default: state_next = S_IDLE;
    endcase
  end

  // Every transition into LOAD consumes the head word.
  always_comb begin
    pop = (state_next == S_LOAD);
  end

`ifdef SHIFT_LOAD_SEQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_count <= '0;
    end else if (pop) begin
      load_count <= load_count + LOAD_COUNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_shift_load_sequencer.sv
// Self-checking bench for shift_load_sequencer (defaults: width 8, depth 4,
// hold 3). A queue-based reference model predicts every edge: a word is
// loaded at the first edge where words are buffered and at least
// HOLD_CYCLES+1 edges have passed since the previous load.
module tb_shift_load_sequencer;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned HOLD  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          load;
  logic [DW-1:0] load_value;
  logic          busy;
`ifdef SHIFT_LOAD_SEQ_STATS_EN
  logic [7:0]    load_count;
`endif

  shift_load_sequencer #(
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (DEPTH),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .load       (load),
    .load_value (load_value),
    .busy       (busy)
`ifdef SHIFT_LOAD_SEQ_STATS_EN
    ,
    .load_count (load_count)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_value = '0;
  int            cyc = 0;
  int            last_load = -100;
  int unsigned   m_count = 0;
  logic [DW-1:0] obs[$];

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, compare.
  task automatic step(input logic v, input logic [DW-1:0] d, output logic acc);
    logic pre_nonempty;
    logic pre_ready;
    in_valid = v;
    in_data  = d;
    pre_nonempty = (q.size() != 0);
    pre_ready    = (q.size() < DEPTH);
    @(posedge clk);
    cyc++;
    if (pre_nonempty && (cyc - last_load) > int'(HOLD)) begin
      m_value   = q.pop_front();
      last_load = cyc;
      m_count++;
    end
    acc = v && pre_ready;
    if (acc) q.push_back(d);
    #1;
    check("load", load, (last_load == cyc));
    check("load_value", load_value, m_value);
    check("busy", busy, (q.size() != 0) || ((cyc - last_load) <= int'(HOLD)));
    check("in_ready", in_ready, (q.size() < DEPTH));
`ifdef SHIFT_LOAD_SEQ_STATS_EN
    check("load_count", load_count, m_count % 256);
`endif
    if (load) obs.push_back(load_value);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, a);
  endtask

  // Assert reset away from a clock edge; outputs must clear before any edge.
  task automatic apply_reset();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_load", load, 0);
    check("rst_load_value", load_value, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef SHIFT_LOAD_SEQ_STATS_EN
    check("rst_load_count", load_count, 0);
`endif
    @(posedge clk);
    #2;
    rst = 1'b0;
    q.delete();
    m_value   = '0;
    last_load = cyc - 100;
    m_count   = 0;
  endtask

  initial begin
    logic a;
    logic          pend_v;
    logic [DW-1:0] pend_d;
    int            rate;
    int            next;

    // Power-on reset, checked before the first clock edge
    #1;
    check("por_load", load, 0);
    check("por_load_value", load_value, 0);
    check("por_busy", busy, 0);
    check("por_in_ready", in_ready, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Single word
    step(1'b1, 8'h41, a);
    step(1'b0, '0, a);
    check("single_load", load, 1);
    check("single_value", load_value, 8'h41);
    idle(HOLD);
    idle(1);
    check("single_idle_busy", busy, 0);

    // Three consecutive words
    obs.delete();
    step(1'b1, 8'h10, a);
    step(1'b1, 8'h20, a);
    step(1'b1, 8'h30, a);
    idle(14);
    check("three_n", obs.size(), 3);
    check("three_last", load_value, 8'h30);

    // Back-pressure: eight words with valid held high
    obs.delete();
    next = 1;
    for (int i = 0; i < 100 && next <= 8; i++) begin
      step(1'b1, DW'(next), a);
      if (a) next++;
    end
    check("bp_all_pushed", next, 9);
    in_valid = 1'b0;
    idle(40);
    check("bp_n", obs.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < obs.size()) check("bp_order", obs[i], i + 1);

    // Reset while holding after the first of three loads
    step(1'b1, 8'hAA, a);
    step(1'b1, 8'hBB, a);
    step(1'b1, 8'hCC, a);
    step(1'b0, '0, a);
    apply_reset();
    obs.delete();
    idle(20);
    check("rst_no_loads", obs.size(), 0);

    // Randomized traffic with varying offered load
    pend_v = 1'b0;
    pend_d = '0;
    for (int blk = 0; blk < 4; blk++) begin
      rate = (blk == 0) ? 20 : (blk == 1) ? 90 : (blk == 2) ? 50 : 100;
      for (int i = 0; i < 150; i++) begin
        if (!pend_v) begin
          pend_v = ($urandom_range(0, 99) < rate);
          pend_d = DW'($urandom);
        end
        step(pend_v, pend_d, a);
        if (a) pend_v = 1'b0;
      end
    end
    in_valid = 1'b0;
    idle(30);
    check("rand_drained_busy", busy, 0);

`ifdef SHIFT_LOAD_SEQ_STATS_EN
    apply_reset();
    step(1'b1, 8'h01, a);
    step(1'b1, 8'h02, a);
    step(1'b1, 8'h03, a);
    idle(14);
    check("stats_three", load_count, 3);
    next = 0;
    for (int i = 0; i < 2000 && next < 256; i++) begin
      step(1'b1, DW'(next), a);
      if (a) next++;
    end
    in_valid = 1'b0;
    idle(30);
    check("stats_wrap", load_count, 3);
    apply_reset();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
